scan_scheduler: RTL

SCAN_SCHEDULER -- requirements
Module: scan_scheduler

---
 rtl/scan_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/scan_scheduler.sv
// Two-scanner job sequencer. It alternates start pulses between scanners A and B
// and arbitrates a single transfer channel with fixed-length grants.
module scan_scheduler #(
    parameter int FULL     = 100,
    parameter int XFER_LEN = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scan_req,
    input  logic [3:0] num_jobs,
    input  logic [6:0] cnt_a,
    input  logic [6:0] cnt_b,
    input  logic       rdy_a,
    input  logic       rdy_b,
    input  logic       half_a,
    input  logic       half_b,
    output logic       start_a,
    output logic       start_b,
    output logic       xfer_a,
    output logic       xfer_b,
    output logic       stby,
    output logic       busy,
    output logic       done,
    output logic       err
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [7:0] FULL_W  = 8'(FULL);
    localparam logic [7:0] TIMER_W = 8'(XFER_LEN - 1);

    state_t     state, state_nx;
    logic [3:0] jobs, started, done_cnt;
    logic [7:0] timer;
    logic       ptr;
    logic       pend_a, pend_b, prefer_b;
    logic       half_a_q, half_b_q, rdy_a_q, rdy_b_q;

    logic active, accept, launch, finish, free, grant_end;
    logic rise_a, rise_b, half_rise, req_a, req_b, gnt_ok, grant_a, grant_b;
    logic start_a_d, start_b_d, xfer_a_d, xfer_b_d, stby_d, busy_d, done_d, err_d;

    assign active    = (state != IDLE);
    assign accept    = (state == IDLE) && scan_req && (num_jobs != 4'd0);
    assign rise_a    = rdy_a & ~rdy_a_q;
    assign rise_b    = rdy_b & ~rdy_b_q;
    assign half_rise = ptr ? (half_b & ~half_b_q) : (half_a & ~half_a_q);
    assign launch    = (state == RUN) && half_rise && (started < jobs);
    assign free      = ~xfer_a & ~xfer_b;
    assign finish    = (state == DRAIN) && (done_cnt == jobs) && free;
    assign grant_end = ~free && (timer == 8'd0);
    assign req_a     = active & (pend_a | rise_a);
    assign req_b     = active & (pend_b | rise_b);
    assign gnt_ok    = active & free & ~finish;
    // prefer_b starts at 0, so a first-ever tie goes to A
    assign grant_a   = gnt_ok & req_a & (~req_b | ~prefer_b);
    assign grant_b   = gnt_ok & req_b & (~req_a | prefer_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = RUN;
            RUN:     if (started == jobs) state_nx = DRAIN;
            DRAIN:   if (finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        start_a_d = accept | (launch & ptr);
        start_b_d = launch & ~ptr;
        xfer_a_d  = grant_a | (xfer_a & ~grant_end);
        xfer_b_d  = grant_b | (xfer_b & ~grant_end);
        stby_d    = (state_nx == IDLE);
        busy_d    = (state_nx != IDLE);
        done_d    = finish;
        err_d     = err
                  | (({1'b0, cnt_a} >= FULL_W) & pend_a & ~xfer_a)
                  | (({1'b0, cnt_b} >= FULL_W) & pend_b & ~xfer_b);
        if (accept) err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_a  <= 1'b0;
            start_b  <= 1'b0;
            xfer_a   <= 1'b0;
            xfer_b   <= 1'b0;
            stby     <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            jobs     <= '0;
            started  <= '0;
            done_cnt <= '0;
            timer    <= '0;
            ptr      <= 1'b0;
            pend_a   <= 1'b0;
            pend_b   <= 1'b0;
            prefer_b <= 1'b0;
            half_a_q <= 1'b0;
            half_b_q <= 1'b0;
            rdy_a_q  <= 1'b0;
            rdy_b_q  <= 1'b0;
        end else begin
            start_a  <= start_a_d;
            start_b  <= start_b_d;
            xfer_a   <= xfer_a_d;
            xfer_b   <= xfer_b_d;
            stby     <= stby_d;
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            half_a_q <= half_a;
            half_b_q <= half_b;
            rdy_a_q  <= rdy_a;
            rdy_b_q  <= rdy_b;

            if (accept) begin
                jobs     <= num_jobs;
                started  <= 4'd1;
                done_cnt <= '0;
                ptr      <= 1'b0;
            end else begin
                if (launch) begin
                    started <= started + 4'd1;
                    ptr     <= ~ptr;
                end
                if (grant_end) done_cnt <= done_cnt + 4'd1;
            end

            if (xfer_a && grant_end)  pend_a <= 1'b0;
            else if (active && rise_a) pend_a <= 1'b1;
            if (xfer_b && grant_end)  pend_b <= 1'b0;
            else if (active && rise_b) pend_b <= 1'b1;

            if (grant_a || grant_b)         timer <= TIMER_W;
            else if (!free && timer != '0)  timer <= timer - 8'd1;

            if (grant_a)      prefer_b <= 1'b1;
            else if (grant_b) prefer_b <= 1'b0;
        end
    end

endmodule
